// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one single-bit step per clock, AMT steps per operation.
// Supports logical shifts, plain rotates and rotates through a carry bit.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [WIDTH-1:0] F,
    input  logic [2:0]       HSEL,
    input  logic [AW-1:0]    AMT,
    input  logic             CI,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_RCL  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RCR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      op;
    logic [AW-1:0]   cnt;

    logic [WIDTH-1:0] step_s;
    logic             step_c;
    logic [WIDTH-1:0] ld_s;
    logic             ld_c;
    logic             ld_fin;

    // One single-bit step of the latched operation; CO doubles as the carry bit.
    always_comb begin
        step_s = S;
        step_c = CO;
        case (op)
            OP_SHL: begin
                step_s = {S[WIDTH-2:0], 1'b0};
                step_c = S[WIDTH-1];
            end
            OP_SHR: begin
                step_s = {1'b0, S[WIDTH-1:1]};
                step_c = S[0];
            end
            OP_RCL: begin
                step_s = {S[WIDTH-2:0], CO};
                step_c = S[WIDTH-1];
            end
            OP_ROL: begin
                step_s = {S[WIDTH-2:0], S[WIDTH-1]};
                step_c = S[WIDTH-1];
            end
            OP_ROR: begin
                step_s = {S[0], S[WIDTH-1:1]};
                step_c = S[0];
            end
            OP_RCR: begin
                step_s = {CO, S[WIDTH-1:1]};
                step_c = S[0];
            end
            default: begin
                step_s = S;
                step_c = CO;
            end
        endcase
    end

    // Load values on acceptance; clear and pass-through finish without stepping.
    always_comb begin
        ld_s   = F;
        ld_c   = 1'b0;
        ld_fin = 1'b0;
        if (HSEL == OP_CLR) begin
            ld_s   = '0;
            ld_fin = 1'b1;
        end else begin
            ld_c   = (HSEL == OP_RCL) || (HSEL == OP_RCR) ? CI : 1'b0;
            ld_fin = (HSEL == OP_LOAD) || (AMT == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= IDLE;
            op    <= OP_LOAD;
            cnt   <= '0;
            S     <= '0;
            CO    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        op    <= HSEL;
                        S     <= ld_s;
                        CO    <= ld_c;
                        cnt   <= (HSEL == OP_CLR) ? '0 : AMT;
                        state <= ld_fin ? FIN : SHIFT;
                        BUSY  <= 1'b1;
                        DONE  <= ld_fin;
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                SHIFT: begin
                    S   <= step_s;
                    CO  <= step_c;
                    cnt <= cnt - AW'(1);
                    // The step taken with one remaining is the last one.
                    if (cnt <= AW'(1)) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter AW, default 3, width of the shift-amount port (AW >= 1).
REQ-003 The block SHALL have port CLK, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RSTN, input, 1 bit, reset that is synchronous and active-low.
REQ-005 The block SHALL have port START, input, 1 bit, request to begin an operation.
REQ-006 The block SHALL have port F, input, WIDTH bits, operand data.
REQ-007 The block SHALL have port HSEL, input, 3 bits, operation select.
REQ-008 The block SHALL have port AMT, input, AW bits, number of single-bit steps (0 to 2^AW-1).
REQ-009 The block SHALL have port CI, input, 1 bit, carry-in for the carry rotates.
REQ-010 The block SHALL have port S, output, WIDTH bits, registered result.
REQ-011 The block SHALL have port CO, output, 1 bit, registered carry-out.
REQ-012 The block SHALL have port BUSY, output, 1 bit, high whenever the state is not IDLE.
REQ-013 The block SHALL have port DONE, output, 1 bit, one-cycle pulse marking a valid S/CO.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and FIN; DONE = (state==FIN); BUSY = (state!=IDLE).
REQ-015 START SHALL be accepted only in IDLE; START in SHIFT or FIN is ignored, not queued.
REQ-016 On acceptance the block SHALL load S<=F, CNT<=AMT and latch HSEL; C<=CI for HSEL 100/111, else C<=0.
REQ-017 On acceptance the next state SHALL be FIN when HSEL is 000 or 011 or AMT==0, else SHIFT.
REQ-018 For HSEL=011 the load SHALL be S<=0, C<=0, ignoring F and AMT.
REQ-019 In SHIFT, one step per cycle SHALL apply to S and C as follows:
  - 001 logical left: S<={S[W-2:0],0}, C<=S[W-1]
  - 010 logical right: S<={0,S[W-1:1]}, C<=S[0]
  - 100 rotate left through carry: S<={S[W-2:0],C}, C<=S[W-1]
  - 101 rotate left: S<={S[W-2:0],S[W-1]}, C<=S[W-1]
  - 110 rotate right: S<={S[0],S[W-1:1]}, C<=S[0]
  - 111 rotate right through carry: S<={C,S[W-1:1]}, C<=S[0]
REQ-020 CNT SHALL decrement each SHIFT cycle; the step taken with CNT==1 SHALL move the state to FIN.
REQ-021 Latency SHALL be AMT+1 cycles from the accepting edge to DONE high, or 1 cycle for 000/011/AMT==0; FIN SHALL return to IDLE after one cycle.
REQ-022 CO SHALL equal C; S and CO SHALL show intermediate values during SHIFT and SHALL hold their FIN values in IDLE until the next accepted START.
REQ-023 F, HSEL, AMT and CI changes after acceptance SHALL NOT affect the running operation.
REQ-024 AMT >= WIDTH SHALL NOT be special-cased: logical shifts yield S=0, and rotates keep wrapping.
REQ-025 Back-to-back operation SHALL be possible: START high in the IDLE cycle after FIN is accepted, for a throughput of AMT+2 cycles per operation.

Reset
REQ-026 RSTN low at a rising CLK edge SHALL force state=IDLE, S=0, CO=0, CNT=0, BUSY=0 and DONE=0, with priority over START.
REQ-027 Reset during SHIFT or FIN SHALL abort the operation without a DONE pulse; START is not accepted in any cycle where RSTN is low.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, HSEL=101, F=8'h81, AMT=3 -> DONE 4 cycles after acceptance, S=8'h0C, CO=0.
REQ-029 The bench SHALL cover: HSEL=100, F=8'h80, CI=0, AMT=2 -> intermediate S=8'h00 with CO=1, then S=8'h01 with CO=0 and DONE.
REQ-030 The bench SHALL cover: HSEL=010, F=8'h0B, AMT=2 -> S=8'h02, CO=1; then HSEL=110, F=8'h5A, AMT=0 -> DONE 1 cycle later, S=8'h5A, CO=0.
REQ-031 The bench SHALL cover: HSEL=011, F=8'hFF, AMT=5 -> DONE 1 cycle later, S=8'h00, CO=0, BUSY high for exactly 1 cycle.
REQ-032 The bench SHALL cover: WIDTH=16, AW=4, HSEL=001, F=16'h8001, AMT=15 -> DONE 16 cycles after acceptance, S=16'h8000, CO=0.
REQ-033 The bench SHALL cover: START pulsed while BUSY is ignored (the result matches a single operation), and RSTN low mid-SHIFT -> next cycle IDLE, S=0, CO=0, no DONE.
